pipeline_dot_acc: RTL and testbench

//   Parametrised 2-stage pipelined dot-product unit: C = sum(A[i]*B[i]), i=0..N-1.

---
 rtl/pipeline_dot_acc.sv | 117 +++++++++++
 tb/tb_pipeline_dot_acc.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_dot_acc.sv
// Two-stage pipelined N-lane unsigned dot product with optional running accumulate,
// global stall, valid tracking and a sticky accumulator-wrap flag.

module dot_lane #(
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ld,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] p
);
  localparam int PW = 2 * W;

  // Product register holds its value on bubbles so idle lanes do not toggle.
  always_ff @(posedge clk) begin
    if (rst)     p <= '0;
    else if (ld) p <= PW'(a) * PW'(b);
  end
endmodule

module pipeline_dot_acc #(
  parameter int N     = 2,
  parameter int W     = 32,
  parameter int OUT_W = 2 * W + 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             InValid,
  input  logic [N*W-1:0]   A,
  input  logic [N*W-1:0]   B,
  input  logic             Mode,
  input  logic             AccClr,
  input  logic             Stall,
  output logic             OutValid,
  output logic [OUT_W-1:0] C,
  output logic             Overflow
);
  localparam int PW     = 2 * W;
  localparam int STAGES = 2;

  generate
    if (OUT_W < 2 * W + $clog2(N)) begin : g_bad_width
      $error("pipeline_dot_acc: OUT_W too narrow for an exact sum of N products");
    end
  endgenerate

  logic [N-1:0][PW-1:0] p;
  logic [STAGES-1:0]    vld_pipe;
  logic                 m1;
  logic                 c1;
  logic                 ld;
  logic [OUT_W-1:0]     sum;
  logic [OUT_W:0]       acc;

  assign ld = !Reset && !Stall && InValid;

  genvar i;
  generate
    for (i = 0; i < N; i++) begin : g_lane
      dot_lane #(.W(W)) u_lane (
        .clk (Clk),
        .rst (Reset),
        .ld  (ld),
        .a   (A[i*W +: W]),
        .b   (B[i*W +: W]),
        .p   (p[i])
      );
    end
  endgenerate

  // Stage-1 control travels every unstalled cycle, so an AccClr on a bubble still lands.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      vld_pipe <= '0;
      m1       <= 1'b0;
      c1       <= 1'b0;
    end else if (!Stall) begin
      vld_pipe <= {vld_pipe[STAGES-2:0], InValid};
      m1       <= Mode;
      c1       <= AccClr;
    end
  end

  always_comb begin
    sum = '0;
    for (int k = 0; k < N; k++) sum = sum + OUT_W'(p[k]);
  end

  // One extra bit captures the wrap that sets the sticky flag.
  assign acc = {1'b0, C} + {1'b0, sum};

  always_ff @(posedge Clk) begin
    if (Reset) begin
      C        <= '0;
      Overflow <= 1'b0;
    end else if (!Stall) begin
      if (vld_pipe[0]) begin
        if (!m1) begin
          C <= sum;
        end else if (c1) begin
          C        <= sum;
          Overflow <= 1'b0;
        end else begin
          C <= acc[OUT_W-1:0];
          if (acc[OUT_W]) Overflow <= 1'b1;
        end
      end else if (c1) begin
        C        <= '0;
        Overflow <= 1'b0;
      end
    end
  end

  assign OutValid = vld_pipe[STAGES-1];
endmodule

// File: tb/tb_pipeline_dot_acc.sv
// Bench for pipeline_dot_acc: three parameterisations share control, a beat-order model
// feeds per-instance scoreboards, and directed tasks check latency, stall and wrap cases.

module tb_pipeline_dot_acc;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b0, in_valid = 1'b0, mode = 1'b0, acc_clr = 1'b0, stall = 1'b0;
  logic [63:0] a2 = '0, b2 = '0;
  logic [7:0]  a4 = '0, b4 = '0;
  logic [31:0] a6 = '0, b6 = '0;
  logic        ov2, ov4, ov6, of2, of4, of6;
  logic [71:0] c2;
  logic [8:0]  c4;
  logic [23:0] c6;

  pipeline_dot_acc #(.N(2), .W(32), .OUT_W(72)) u2 (
    .Clk(clk), .Reset(rst), .InValid(in_valid), .A(a2), .B(b2), .Mode(mode),
    .AccClr(acc_clr), .Stall(stall), .OutValid(ov2), .C(c2), .Overflow(of2));
  pipeline_dot_acc #(.N(2), .W(4), .OUT_W(9)) u4 (
    .Clk(clk), .Reset(rst), .InValid(in_valid), .A(a4), .B(b4), .Mode(mode),
    .AccClr(acc_clr), .Stall(stall), .OutValid(ov4), .C(c4), .Overflow(of4));
  pipeline_dot_acc #(.N(4), .W(8), .OUT_W(24)) u6 (
    .Clk(clk), .Reset(rst), .InValid(in_valid), .A(a6), .B(b6), .Mode(mode),
    .AccClr(acc_clr), .Stall(stall), .OutValid(ov6), .C(c6), .Overflow(of6));

  typedef struct {
    logic [79:0] c;
    logic        o;
  } exp_t;

  exp_t q2[$], q4[$], q6[$];
  exp_t e2, e4, e6;
  logic [79:0] mc2 = '0, mc4 = '0, mc6 = '0;
  logic        mo2 = 1'b0, mo4 = 1'b0, mo6 = 1'b0;
  int compared = 0, mismatched = 0;
  logic live_q = 1'b0, frz_q = 1'b0;
  logic [23:0] pc6;
  logic        pov6;

  function automatic logic [79:0] sum2(input logic [63:0] a, input logic [63:0] b);
    return 80'(a[31:0]) * 80'(b[31:0]) + 80'(a[63:32]) * 80'(b[63:32]);
  endfunction

  function automatic logic [79:0] sum4(input logic [7:0] a, input logic [7:0] b);
    return 80'(a[3:0]) * 80'(b[3:0]) + 80'(a[7:4]) * 80'(b[7:4]);
  endfunction

  function automatic logic [79:0] sum6(input logic [31:0] a, input logic [31:0] b);
    logic [79:0] s = '0;
    for (int k = 0; k < 4; k++) s = s + 80'(a[k*8 +: 8]) * 80'(b[k*8 +: 8]);
    return s;
  endfunction

  // Transaction-order model: beats retire in issue order, so state can advance at issue time.
  task automatic model_beat(input logic v, input logic m, input logic clr, input int ow,
                            input logic [79:0] s, inout logic [79:0] c, inout logic o);
    logic [80:0] t;
    logic [80:0] lim;
    lim = 81'd1 << ow;
    if (v) begin
      if (!m) begin
        c = s;
      end else if (clr) begin
        c = s;
        o = 1'b0;
      end else begin
        t = {1'b0, c} + {1'b0, s};
        if (t >= lim) begin
          o = 1'b1;
          t = t - lim;
        end
        c = t[79:0];
      end
    end else if (clr) begin
      c = '0;
      o = 1'b0;
    end
  endtask

  task automatic step(input logic v, input logic m, input logic clr, input logic st,
                      input logic r = 1'b0);
    rst = r; in_valid = v; mode = m; acc_clr = clr; stall = st;
    if (r) begin
      q2.delete(); q4.delete(); q6.delete();
      mc2 = '0; mc4 = '0; mc6 = '0; mo2 = 1'b0; mo4 = 1'b0; mo6 = 1'b0;
    end else if (!st) begin
      model_beat(v, m, clr, 72, sum2(a2, b2), mc2, mo2);
      model_beat(v, m, clr, 9,  sum4(a4, b4), mc4, mo4);
      model_beat(v, m, clr, 24, sum6(a6, b6), mc6, mo6);
      if (v) begin
        q2.push_back('{mc2, mo2});
        q4.push_back('{mc4, mo4});
        q6.push_back('{mc6, mo6});
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    live_q = !rst && !stall;
    frz_q  = stall && !rst;
  end

  always @(negedge clk) begin
    if (live_q && ov2 === 1'b1) begin
      compared++;
      if (q2.size() == 0) begin
        mismatched++; $display("FAIL sb2_unexpected c=%0d no beat outstanding", c2);
      end else begin
        e2 = q2.pop_front();
        if (c2 !== e2.c[71:0] || of2 !== e2.o) begin
          mismatched++;
          $display("FAIL sb2 c=%0d of=%b want c=%0d of=%b", c2, of2, e2.c[71:0], e2.o);
        end
      end
    end
    if (live_q && ov4 === 1'b1) begin
      compared++;
      if (q4.size() == 0) begin
        mismatched++; $display("FAIL sb4_unexpected c=%0d no beat outstanding", c4);
      end else begin
        e4 = q4.pop_front();
        if (c4 !== e4.c[8:0] || of4 !== e4.o) begin
          mismatched++;
          $display("FAIL sb4 c=%0d of=%b want c=%0d of=%b", c4, of4, e4.c[8:0], e4.o);
        end
      end
    end
    if (live_q && ov6 === 1'b1) begin
      compared++;
      if (q6.size() == 0) begin
        mismatched++; $display("FAIL sb6_unexpected c=%0d no beat outstanding", c6);
      end else begin
        e6 = q6.pop_front();
        if (c6 !== e6.c[23:0] || of6 !== e6.o) begin
          mismatched++;
          $display("FAIL sb6 c=%0d of=%b want c=%0d of=%b", c6, of6, e6.c[23:0], e6.o);
        end
      end
    end
    if (frz_q) begin
      compared++;
      if (c6 !== pc6 || ov6 !== pov6) begin
        mismatched++;
        $display("FAIL stall_hold6 c=%0d ov=%b want c=%0d ov=%b", c6, ov6, pc6, pov6);
      end
    end
    pc6  = c6;
    pov6 = ov6;
  end

  task automatic test_reset;
    step(0, 0, 0, 0, 1);
    compared++;
    if (c2 !== '0 || ov2 !== 1'b0 || of2 !== 1'b0 || c4 !== '0 || of4 !== 1'b0 ||
        c6 !== '0 || ov6 !== 1'b0 || of6 !== 1'b0) begin
      mismatched++;
      $display("FAIL reset c2=%0d ov2=%b of2=%b c4=%0d of4=%b c6=%0d want all 0",
               c2, ov2, of2, c4, of4, c6);
    end
  endtask

  task automatic test_plain;
    a2 = {32'd2, 32'd0}; b2 = {32'd3, 32'd1}; step(1, 0, 0, 0);
    a2 = {32'd3, 32'd1}; b2 = {32'd4, 32'd1}; step(1, 0, 0, 0);
    compared++;
    if (c2 !== 72'd6 || ov2 !== 1'b1) begin
      mismatched++; $display("FAIL plain_first c=%0d ov=%b want c=6 ov=1", c2, ov2);
    end
    step(0, 0, 0, 0);
    compared++;
    if (c2 !== 72'd13 || ov2 !== 1'b1) begin
      mismatched++; $display("FAIL plain_second c=%0d ov=%b want c=13 ov=1", c2, ov2);
    end
    step(0, 0, 0, 0);
    compared++;
    if (c2 !== 72'd13 || ov2 !== 1'b0) begin
      mismatched++; $display("FAIL plain_idle c=%0d ov=%b want c=13 ov=0", c2, ov2);
    end
  endtask

  task automatic test_accumulate;
    a2 = {32'd2, 32'd0}; b2 = {32'd3, 32'd1}; step(1, 1, 1, 0);
    a2 = {32'd3, 32'd1}; b2 = {32'd4, 32'd1}; step(1, 1, 0, 0);
    compared++;
    if (c2 !== 72'd6 || ov2 !== 1'b1 || of2 !== 1'b0) begin
      mismatched++; $display("FAIL acc_first c=%0d ov=%b of=%b want c=6 ov=1 of=0", c2, ov2, of2);
    end
    step(0, 0, 0, 0);
    compared++;
    if (c2 !== 72'd19 || of2 !== 1'b0) begin
      mismatched++; $display("FAIL acc_second c=%0d of=%b want c=19 of=0", c2, of2);
    end
    step(0, 0, 0, 0);
  endtask

  task automatic test_stall;
    a2 = {32'd2, 32'd0}; b2 = {32'd3, 32'd1}; step(1, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      a2 = {$urandom, $urandom}; b2 = {$urandom, $urandom};
      step(1, 1, 1, 1);
      compared++;
      if (c2 !== 72'd19 || ov2 !== 1'b0) begin
        mismatched++; $display("FAIL stall_freeze%0d c=%0d ov=%b want c=19 ov=0", k, c2, ov2);
      end
    end
    a2 = {32'd3, 32'd1}; b2 = {32'd4, 32'd1}; step(1, 0, 0, 0);
    compared++;
    if (c2 !== 72'd6 || ov2 !== 1'b1) begin
      mismatched++; $display("FAIL stall_late c=%0d ov=%b want c=6 ov=1", c2, ov2);
    end
    step(1, 1, 1, 1);
    compared++;
    if (c2 !== 72'd6 || ov2 !== 1'b1) begin
      mismatched++; $display("FAIL stall_hold_valid c=%0d ov=%b want c=6 ov=1", c2, ov2);
    end
    step(0, 0, 0, 0);
    compared++;
    if (c2 !== 72'd13 || ov2 !== 1'b1) begin
      mismatched++; $display("FAIL stall_second c=%0d ov=%b want c=13 ov=1", c2, ov2);
    end
    step(0, 0, 0, 0);
    compared++;
    if (ov2 !== 1'b0) begin
      mismatched++; $display("FAIL stall_no_dup ov=%b want 0", ov2);
    end
  endtask

  task automatic test_overflow;
    a4 = 8'hFF; b4 = 8'hFF;
    step(1, 1, 1, 0);
    step(1, 1, 0, 0);
    compared++;
    if (c4 !== 9'd450 || of4 !== 1'b0 || ov4 !== 1'b1) begin
      mismatched++; $display("FAIL ovf_first c=%0d of=%b ov=%b want c=450 of=0 ov=1", c4, of4, ov4);
    end
    step(0, 0, 1, 0);
    compared++;
    if (c4 !== 9'd388 || of4 !== 1'b1 || ov4 !== 1'b1) begin
      mismatched++; $display("FAIL ovf_wrap c=%0d of=%b ov=%b want c=388 of=1 ov=1", c4, of4, ov4);
    end
    step(0, 0, 0, 0);
    compared++;
    if (c4 !== 9'd0 || of4 !== 1'b0 || ov4 !== 1'b0) begin
      mismatched++; $display("FAIL ovf_clear c=%0d of=%b ov=%b want c=0 of=0 ov=0", c4, of4, ov4);
    end
  endtask

  task automatic test_reset_in_flight;
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    compared++;
    if (c4 !== 9'd388 || of4 !== 1'b1) begin
      mismatched++; $display("FAIL rif_setup c=%0d of=%b want c=388 of=1", c4, of4);
    end
    step(1, 1, 0, 1);
    step(1, 1, 0, 1, 1);
    compared++;
    if (c4 !== 9'd0 || ov4 !== 1'b0 || of4 !== 1'b0 || c2 !== '0 || ov2 !== 1'b0) begin
      mismatched++;
      $display("FAIL rif_reset c4=%0d ov4=%b of4=%b c2=%0d ov2=%b want all 0", c4, ov4, of4, c2, ov2);
    end
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 0, 0);
      compared++;
      if (ov4 !== 1'b0 || ov2 !== 1'b0 || c4 !== 9'd0) begin
        mismatched++; $display("FAIL rif_stale%0d ov4=%b ov2=%b c4=%0d want 0 0 0", k, ov4, ov2, c4);
      end
    end
  endtask

  task automatic test_random;
    for (int n = 0; n < 1000; n++) begin
      a2 = {$urandom, $urandom}; b2 = {$urandom, $urandom};
      a4 = 8'($urandom); b4 = 8'($urandom);
      a6 = $urandom; b6 = $urandom;
      step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
           $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0);
    end
    for (int k = 0; k < 3; k++) step(0, 0, 0, 0);
    compared++;
    if (q2.size() != 0 || q4.size() != 0 || q6.size() != 0) begin
      mismatched++;
      $display("FAIL rand_drain left=%0d/%0d/%0d want 0/0/0", q2.size(), q4.size(), q6.size());
    end
  endtask

  initial begin
    test_reset;
    test_plain;
    test_accumulate;
    test_stall;
    test_overflow;
    test_reset_in_flight;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
